ps2_rx: RTL and testbench

//   PS/2 keyboard receiver feeding game_logic's ps2_valid/ps2_data inputs.

---
 rtl/ps2_rx.sv | 149 ++++++++++++++
 tb/tb_ps2_rx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit deframer, E0/F0 prefix stripping.
// Optional PS2_PARITY_CHECK_EN: when defined, odd-parity failures drop the byte and flag an error.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_valid,
  output logic [7:0] ps2_data,
  output logic       ext_o,
  output logic       frame_err_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, nxt;
  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  clk_s, dat_s, all_lo, all_hi, strobe;
  logic [7:0]            shift;
  logic [2:0]            bit_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  timeout, par_ok, byte_ok, err_c;
  logic                  ext_f, brk_f;
`ifdef PS2_PARITY_CHECK_EN
  logic                  par_bit;
`endif

  // Lines idle high; resetting the synchronisers to 1 avoids a false strobe on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_data_i};
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_s};
      if (all_lo)      filt_clk <= 1'b0;
      else if (all_hi) filt_clk <= 1'b1;
    end
  end

  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign all_lo  = (filt_sr == '0);
  assign all_hi  = (filt_sr == '1);
  assign strobe  = filt_clk & all_lo;
  assign timeout = (state != IDLE) && (to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (timeout) nxt = IDLE;
    else if (strobe) begin
      case (state)
        IDLE:    if (!dat_s) nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) nxt = PARITY;
        PARITY:  nxt = STOP;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ok = 1'b0;
    err_c   = 1'b0;
    if (timeout) err_c = 1'b1;
    else if (strobe && state == STOP) begin
      if (dat_s && par_ok) byte_ok = 1'b1;
      else                 err_c   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
    end else if (strobe) begin
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shift   <= {dat_s, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
`ifdef PS2_PARITY_CHECK_EN
        PARITY: par_bit <= dat_s;
`endif
        default: ;
      endcase
    end
  end

  // Saturating idle counter; only meaningful between strobes of an open frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         to_cnt <= '0;
    else if (state == IDLE || strobe) to_cnt <= '0;
    else if (to_cnt != '1)            to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_valid   <= 1'b0;
      ps2_data    <= 8'h00;
      ext_o       <= 1'b0;
      frame_err_o <= 1'b0;
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
    end else begin
      ps2_valid   <= 1'b0;
      frame_err_o <= err_c;
      if (byte_ok) begin
        if (shift == 8'hE0)      ext_f <= 1'b1;
        else if (shift == 8'hF0) brk_f <= 1'b1;
        else begin
          if (!brk_f) begin
            ps2_data  <= shift;
            ext_o     <= ext_f;
            ps2_valid <= 1'b1;
          end
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are bit-banged on the raw lines, expected pulses queued.
module tb_ps2_rx;
  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 25;
  localparam int LAT  = 11;

  logic       clk = 1'b0, rst = 1'b0;
  logic       ps2_clk_i = 1'b1, ps2_data_i = 1'b1;
  logic       ps2_valid, ext_o, frame_err_o;
  logic [7:0] ps2_data;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_valid(ps2_valid), .ps2_data(ps2_data), .ext_o(ext_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; logic [7:0] data; bit ext; bit lat; } exp_t;
  exp_t       sb[$];
  int         n_vec = 0, n_mis = 0;
  int         cyc = 0, t_stop = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_ext = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h @cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_ok(input logic [7:0] d, input bit e);
    m_data = d; m_ext = e;
    sb.push_back('{err: 1'b0, data: d, ext: e, lat: 1'b1});
  endtask

  task automatic exp_err(input bit lat);
    sb.push_back('{err: 1'b1, data: m_data, ext: m_ext, lat: lat});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && (ps2_valid || frame_err_o)) begin
      if (sb.size() == 0) chk("spurious", {ps2_valid, frame_err_o}, 0);
      else begin
        e = sb.pop_front();
        chk("kind", {ps2_valid, frame_err_o}, e.err ? 2'b01 : 2'b10);
        chk("data", ps2_data, e.data);
        chk("ext", ext_o, e.ext);
        if (e.lat) chk("latency", cyc - t_stop, LAT);
      end
    end
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data changes while clock is high, host samples on the falling edge.
  task automatic send_bit(input logic v, input bit g, input bit last);
    wcyc(1);
    ps2_data_i = v;
    if (g) begin
      wcyc(5); ps2_clk_i = 1'b0; wcyc(FL - 1); ps2_clk_i = 1'b1; wcyc(HALF - 5 - FL + 1);
    end else wcyc(HALF);
    ps2_clk_i = 1'b0;
    if (last) t_stop = cyc;
    if (g) begin
      wcyc(5); ps2_clk_i = 1'b1; wcyc(FL - 1); ps2_clk_i = 1'b0; wcyc(HALF - 5 - FL + 1);
    end else wcyc(HALF);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit stop,
                      input int nbits, input bit glitch);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i == 3 || i == 6), i == 10);
    ps2_data_i = 1'b1;
    wcyc(2 * HALF);
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 11, 1'b0);
  endtask

  initial begin
    wcyc(3);
    chk("rst_valid", ps2_valid, 0);
    chk("rst_data", ps2_data, 8'h00);
    chk("rst_ext", ext_o, 0);
    chk("rst_err", frame_err_o, 0);
    rst = 1'b1;
    wcyc(5);

    exp_ok(8'h1C, 0); good(8'h1C);
    exp_ok(8'h74, 1); good(8'hE0); good(8'h74);
    good(8'hE0); good(8'hF0); good(8'h74);
    chk("brk_hold_data", ps2_data, 8'h74);
    chk("brk_hold_ext", ext_o, 1);
    exp_ok(8'h1C, 0); good(8'h1C);

`ifdef PS2_PARITY_CHECK_EN
    exp_err(1);
`else
    exp_ok(8'h75, 0);
`endif
    send(8'h75, 1'b1, 1'b1, 11, 1'b0);

    exp_err(1); send(8'h33, 1'b0, 1'b0, 11, 1'b0);
    exp_ok(8'h6B, 0); good(8'h6B);

    exp_err(0); send(8'h55, 1'b0, 1'b1, 5, 1'b0);
    wcyc(TO + 50);
    exp_ok(8'h72, 0); good(8'h72);

    exp_ok(8'h5A, 0); send(8'h5A, 1'b0, 1'b1, 11, 1'b1);

    exp_ok(8'h1C, 0); good(8'h1C);
    exp_ok(8'h1C, 0); good(8'h1C);
    exp_ok(8'h6B, 1); good(8'hE0); good(8'h6B);
    wcyc(20);
    chk("drain_mid", sb.size(), 0);

    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
    wcyc(3);
    rst = 1'b0;
    wcyc(2);
    chk("mrst_valid", ps2_valid, 0);
    chk("mrst_data", ps2_data, 8'h00);
    chk("mrst_ext", ext_o, 0);
    chk("mrst_err", frame_err_o, 0);
    ps2_clk_i = 1'b1; ps2_data_i = 1'b1;
    wcyc(3);
    rst = 1'b1;
    wcyc(5);
    exp_ok(8'h29, 0); good(8'h29);

    wcyc(30);
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
